updown_counter_param: RTL

- Parametrised successor to the 4-bit load/clear/incr up-counter.
- Generalises width and terminal value (modulus), adds down-counting, wrap-vs-saturate mode, a terminal-count flag, a wrap pulse and a sticky overflow flag.
- Used as the general counter primitive in lab datapaths: timers, decade counters and address generators.

---
 rtl/counter_pkg.sv | 19 +
 rtl/updown_counter_param.sv | 96 +++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter family: mode encodings and the
// load-clamping helper used by load-capable counters.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Widest counter the family supports; clamp_load operates at this width.
    localparam int CNT_MAX_W = 16;

    // Limit a parallel-load value to the counter's terminal value.
    function automatic logic [CNT_MAX_W-1:0] clamp_load(
        input logic [CNT_MAX_W-1:0] d,
        input logic [CNT_MAX_W-1:0] max
    );
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, clear, wrap-or-saturate range
// ends, terminal-count flag, one-cycle wrap pulse and sticky overflow flag.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > CNT_MAX_W) begin : g_bad_width
        $fatal(1, "updown_counter_param: WIDTH must be 2..16");
    end
    if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
        $fatal(1, "updown_counter_param: MAX_VAL must be 1..2**WIDTH-1");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $fatal(1, "updown_counter_param: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam bit               SAT  = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    // Next-state selection: clear > load > count > hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clear) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            q_d = WIDTH'(clamp_load(CNT_MAX_W'(d), CNT_MAX_W'(MAXV)));
            if (d > MAXV) begin
                ovf_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q_q == MAXV) begin
                    ovf_d = 1'b1;
                    if (!SAT) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    ovf_d = 1'b1;
                    if (!SAT) begin
                        q_d    = MAXV;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign tc   = up ? (q_q == MAXV) : (q_q == '0);

endmodule
